vga_timing_window: RTL

- Parametrised VGA raster generator and windowed framebuffer reader for the 25 MHz pixel domain.
- Generates horizontal and vertical timing with configurable porches, sync widths and polarity.
- Issues read addresses to a WIN_W x WIN_H video memory placed at (WIN_X, WIN_Y) inside the active area, and delay-aligns sync, blank and colour for a memory of MEM_LAT read latency.
- Sits between the video RAM and the board VGA pins; replaces the fixed 640x480 controller.

---
 rtl/vga_timing_window.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_window.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_timing_window
// Parametrised VGA raster generator with a windowed framebuffer reader for the
// 25 MHz pixel domain. A WIN_W x WIN_H video memory is placed at (WIN_X, WIN_Y)
// inside the active area. Everything outside the window but inside the active
// area shows BORDER_COLOR. Porches and sync are black.
//
// The sync, enable, frame-start and colour outputs all lag the raw counters by
// MEM_LAT+2 cycles:
//   1 cycle      counter -> registered read address
//   MEM_LAT      memory read latency
//   1 cycle      output register
//
// Ports:
//   Clock_25        in   pixel clock
//   Reset           in   asynchronous, active-high
//   oReadAddress    out  video memory read address (registered)
//   iColor          in   memory data, valid MEM_LAT cycles after its address
//   oColor          out  pixel to DAC/pins ({R,G,B} for COLOR_W=3)
//   oHSync          out  horizontal sync, active level SYNC_POL
//   oVSync          out  vertical sync, active level SYNC_POL
//   oDisplayEnable  out  high during active pixels, aligned with oColor
//   oFrameStart     out  one-cycle pulse aligned with output pixel (0,0)
//   oHCount         out  raw horizontal counter (unaligned, debug)
//   oVCount         out  raw vertical counter (unaligned, debug)
// ---------------------------------------------------------------------------
module vga_timing_window #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter bit SYNC_POL     = 1'b0,
   parameter int WIN_X        = 192,
   parameter int WIN_Y        = 112,
   parameter int WIN_W        = 256,
   parameter int WIN_H        = 256,
   parameter int ADDR_W       = 16,
   parameter int COLOR_W      = 3,
   parameter int MEM_LAT      = 1,
   parameter int BORDER_COLOR = 7
) (
   input  logic               Clock_25,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oReadAddress,
   input  logic [COLOR_W-1:0] iColor,
   output logic [COLOR_W-1:0] oColor,
   output logic               oHSync,
   output logic               oVSync,
   output logic               oDisplayEnable,
   output logic               oFrameStart,
   output logic [9:0]         oHCount,
   output logic [9:0]         oVCount
);

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
   localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
   localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
   localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

   localparam logic [9:0]         H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]         V_LAST = 10'(V_TOTAL - 1);
   localparam logic [COLOR_W-1:0] BORDER = COLOR_W'(BORDER_COLOR);

   // ---- elaboration-time parameter checks ----
   if (WIN_X + WIN_W > H_ACTIVE) begin : g_err_win_x
      $error("vga_timing_window: WIN_X + WIN_W exceeds H_ACTIVE");
   end
   if (WIN_Y + WIN_H > V_ACTIVE) begin : g_err_win_y
      $error("vga_timing_window: WIN_Y + WIN_H exceeds V_ACTIVE");
   end
   if (ADDR_W > 32 || (64'(WIN_W) * 64'(WIN_H)) > (64'd1 << ADDR_W)) begin : g_err_addr
      $error("vga_timing_window: window does not fit in ADDR_W address bits");
   end
   if (MEM_LAT < 1) begin : g_err_lat
      $error("vga_timing_window: MEM_LAT must be at least 1");
   end
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_err_cnt
      $error("vga_timing_window: totals exceed the 10-bit counters");
   end

   // Per-pixel flags carried down the alignment delay line.
   typedef struct packed {
      logic win;
      logic de;
      logic hs;   // 1 = sync active (polarity applied at the pins)
      logic vs;
      logic fs;
   } flags_t;

   logic [9:0]  hcnt, vcnt;
   logic [31:0] h32, vcnt32;
   flags_t      raw;
   logic [ADDR_W-1:0]  addr_next;
   logic [COLOR_W-1:0] color_next;
   flags_t      pipe [MEM_LAT+1];

   // ---- stage 0: raster counters ----
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others; blocking here would create order races.
   always_ff @(posedge Clock_25 or posedge Reset) begin
      if (Reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

   assign h32    = 32'(hcnt);
   assign vcnt32 = 32'(vcnt);

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      raw       = '0;
      addr_next = '0;
      raw.de    = (h32 < H_ACTIVE) && (vcnt32 < V_ACTIVE);
      raw.hs    = (h32 >= H_SYNC_BEG) && (h32 < H_SYNC_END);
      raw.vs    = (vcnt32 >= V_SYNC_BEG) && (vcnt32 < V_SYNC_END);
      raw.fs    = (hcnt == '0) && (vcnt == '0);
      raw.win   = raw.de
                  && (h32 >= WIN_X) && (h32 < WIN_X + WIN_W)
                  && (vcnt32 >= WIN_Y) && (vcnt32 < WIN_Y + WIN_H);
      // Row-major offset inside the window; WIN_W need not be a power of two.
      if (raw.win)
         addr_next = ADDR_W'((vcnt32 - WIN_Y) * WIN_W + (h32 - WIN_X));
   end

   // ---- stage 1: read address plus alignment delay line ----
   // pipe[i] holds the raw flags delayed by i+1 cycles, so pipe[MEM_LAT] lines
   // up with iColor for the same pixel.
   // NOTE: the delay line is reset element by element; a cleared line is what
   // guarantees inactive sync/enable until real pixels arrive after Reset.
   always_ff @(posedge Clock_25 or posedge Reset) begin
      if (Reset) begin
         oReadAddress <= '0;
         for (int i = 0; i <= MEM_LAT; i++) pipe[i] <= '0;
      end else begin
         oReadAddress <= addr_next;
         pipe[0]      <= raw;
         for (int i = 1; i <= MEM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // ---- output stage ----
   always_comb begin
      color_next = '0;
      if (pipe[MEM_LAT].win)
         color_next = iColor;
      else if (pipe[MEM_LAT].de)
         color_next = BORDER;
   end

   always_ff @(posedge Clock_25 or posedge Reset) begin
      if (Reset) begin
         oColor         <= '0;
         oDisplayEnable <= 1'b0;
         oFrameStart    <= 1'b0;
         oHSync         <= ~SYNC_POL;
         oVSync         <= ~SYNC_POL;
      end else begin
         oColor         <= color_next;
         oDisplayEnable <= pipe[MEM_LAT].de;
         oFrameStart    <= pipe[MEM_LAT].fs;
         oHSync         <= pipe[MEM_LAT].hs ? SYNC_POL : ~SYNC_POL;
         oVSync         <= pipe[MEM_LAT].vs ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign oHCount = hcnt;
   assign oVCount = vcnt;

endmodule
